serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial add/subtract/compare engine for the controller datapath: latches two WIDTH-bit operands, processes them LSB-first through a single 1-bit full-adder cell with a registered carry, and presents the parallel result plus carry and zero flags on completion. It replaces parallel adders on page and position counters where area matters more than latency. A serial bit stream is exposed for downstream serial consumers.

## Interface
- WIDTH, 16: operand/result width; legal range 2..64.
- i_CLK  in  1  system clock.
- i_RST  in  1  reset, asynchronous, active-high.
- i_CEN  in  1  clock enable; state, counters and outputs change only on i_CLK edges with i_CEN=1.
- i_START  in  1  start request, sampled on enabled edges.
- i_MODE  in  2  operation: 00 ADD, 01 SUB (A−B), 10 CMP (SUB, result not written), 11 ADC (A+B+i_CIN).
- i_CIN  in  1  carry-in, used by ADC only.
- i_A, i_B  in  WIDTH  operands, sampled with an accepted start.
- o_BUSY  out  1  high while in RUN.
- o_DONE  out  1  high for exactly one enabled cycle, in DONE.
- o_SBIT  out  1  current serial sum bit.
- o_SVALID  out  1  o_SBIT valid. Equal to o_BUSY.
- o_S  out  WIDTH  last written result.
- o_COUT  out  1  final carry. For SUB/CMP, 1 means no borrow (A ≥ B unsigned).
- o_ZERO  out  1  final result bits all zero. Valid for every mode, including CMP.

## Operation
- States: IDLE, RUN, DONE.
- **Start acceptance:** accepted on an enabled edge with i_START=1 in IDLE or DONE.
  - i_A, i_B and i_MODE are latched.
  - For SUB/CMP, ~i_B is latched.
  - Carry register loads 1 for SUB/CMP, i_CIN for ADC, 0 for ADD.
  - Bit counter is cleared; zero-accumulator is set to 1; state goes to RUN.
- **RUN:** each enabled edge performs one bit step.
  - The cell adds A[0], B[0] and the carry register.
  - The sum bit shifts into the result shift register from the MSB side.
  - A and B shift right by one.
  - The carry register takes the cell carry-out.
  - zero-accumulator &= ~sum.
  - The counter increments.
  - The edge where the counter equals WIDTH−1 is the last step; state goes to DONE.
- **On entering DONE:**
  - o_COUT takes the final carry; o_ZERO takes the zero-accumulator.
  - o_S takes the shift-register contents, except in CMP, where o_S holds its prior value.
- **DONE:** with no start, the next enabled edge goes to IDLE. A start in DONE goes directly to RUN, giving back-to-back operation.
- i_START in RUN is ignored. It is not queued.
- o_SBIT = combinational cell sum of the current register state. Meaningful only while o_SVALID=1.
- Arithmetic is modulo 2^WIDTH. There is no overflow flag. Signedness is the consumer's concern.
- **Reset:** all registers and outputs go to 0 asynchronously; state goes to IDLE.
  - Reset mid-RUN aborts the operation with no partial result written.
  - o_S, o_COUT and o_ZERO read 0 after reset.

## Timing
- Start accepted at enabled edge E0. o_BUSY=1 from E0 through the last RUN step.
- The bit k step occurs at enabled edge E(k+1).
- The last bit step is at E(WIDTH). o_DONE, o_S and the flags are valid after E(WIDTH), for one enabled cycle.
- Latency from start to done: WIDTH enabled edges. With a back-to-back start, throughput is one operation per WIDTH+1 enabled edges.
- i_CEN=0 freezes everything. Outputs are held, and o_DONE stays high if frozen in DONE.
- Operands may change after E0 without effect.

## Structure
- **Shared package:** mode constants (MODE_ADD, MODE_SUB, MODE_CMP, MODE_ADC) and the state encoding (IDLE, RUN, DONE).
- **Sub-module:** instantiate the team's existing 1-bit FA primitive (i_A, i_B, i_CIN → o_S, o_COUT) as the single arithmetic cell.
- **Top-level contents:** the FSM, the counter, the shift registers and the flag registers.
- The bit counter is $clog2(WIDTH) bits wide.

## Test plan
All scenarios use WIDTH=8 unless stated.
- **ADD:** 0x5A+0x33 → o_S=0x8D, o_COUT=0, o_ZERO=0. o_DONE at the 8th enabled edge after start. o_SBIT sequence LSB-first: 1,0,1,1,0,0,0,1.
- **SUB:**
  - 0x10−0x20 → o_S=0xF0, o_COUT=0 (borrow).
  - Then 0x20−0x20 → o_S=0x00, o_COUT=1, o_ZERO=1.
- **ADC:** 0xFF+0x00 with i_CIN=1 → o_S=0x00, o_COUT=1, o_ZERO=1. The same stimulus in ADD → 0xFF, o_COUT=0.
- **CMP:**
  - After ADD gives 0x8D, CMP 0x05 vs 0x07 → o_S stays 0x8D, o_COUT=0, o_ZERO=0.
  - CMP 0x07 vs 0x07 → o_ZERO=1.
- **Clock enable, busy and back-to-back:**
  - i_CEN high 1 cycle in 3 → same results as with i_CEN held high, latency 8 enabled edges.
  - i_START pulsed mid-RUN → ignored.
  - Start asserted in DONE → new RUN with no IDLE cycle.
- **Reset:**
  - i_RST asserted asynchronously after bit 4 of an ADD → all outputs 0 immediately, state IDLE.
  - Next start 0x01+0x01 → o_S=0x02.
  - WIDTH=2 build: 0b11+0b01 → 0b00, o_COUT=1.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract/compare engine.
// Provides the operation mode codes and the controller state encoding.
package serial_addsub_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_CMP = 2'b10;
  localparam logic [1:0] MODE_ADC = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_fa.sv
// 1-bit full adder cell.
// Ports: i_A, i_B, i_CIN - addend bits and carry in
//        o_S, o_COUT     - sum bit and carry out
module serial_addsub_fa (
  input  logic i_A,
  input  logic i_B,
  input  logic i_CIN,
  output logic o_S,
  output logic o_COUT
);

  assign o_S    = i_A ^ i_B ^ i_CIN;
  assign o_COUT = (i_A & i_B) | (i_CIN & (i_A ^ i_B));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract/compare engine. Operands are latched on an accepted
// start and processed LSB-first through one full-adder cell with a registered
// carry; the parallel result and carry/zero flags are presented on completion.
// Ports: i_CLK, i_RST (async, active-high), i_CEN clock enable,
//        i_START, i_MODE (ADD/SUB/CMP/ADC), i_CIN, i_A, i_B operands;
//        o_BUSY, o_DONE status; o_SBIT/o_SVALID serial sum stream;
//        o_S result, o_COUT final carry (no-borrow for SUB/CMP), o_ZERO.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_CEN,
  input  logic             i_START,
  input  logic [1:0]       i_MODE,
  input  logic             i_CIN,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic             o_SBIT,
  output logic             o_SVALID,
  output logic [WIDTH-1:0] o_S,
  output logic             o_COUT,
  output logic             o_ZERO
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nx;
  logic               start_acc;
  logic               step;
  logic               last_step;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sr_q;
  logic [1:0]         mode_q;
  logic               carry_q;
  logic               zacc_q;
  logic [WIDTH-1:0]   s_q;
  logic               cout_q;
  logic               zero_q;

  logic               cell_s;
  logic               cell_cout;
  logic               is_sub;

  // Single arithmetic cell shared by every bit step
  serial_addsub_fa u_fa (
    .i_A   (a_q[0]),
    .i_B   (b_q[0]),
    .i_CIN (carry_q),
    .o_S   (cell_s),
    .o_COUT(cell_cout)
  );

  assign is_sub = (i_MODE == MODE_SUB) || (i_MODE == MODE_CMP);

  // State register
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and step control; nothing advances without i_CEN
  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    if (i_CEN) begin
      case (state)
        IDLE: begin
          if (i_START) begin
            start_acc = 1'b1;
            state_nx  = RUN;
          end
        end
        RUN: begin
          step = 1'b1;
          if (cnt == CNT_LAST) begin
            last_step = 1'b1;
            state_nx  = DONE;
          end
        end
        DONE: begin
          // A start here chains straight into the next operation
          if (i_START) begin
            start_acc = 1'b1;
            state_nx  = RUN;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Operand/result shifters, counter and flag registers
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else if (start_acc) begin
      a_q     <= i_A;
      b_q     <= is_sub ? ~i_B : i_B;
      mode_q  <= i_MODE;
      // Subtraction is A + ~B + 1; ADC injects the external carry
      carry_q <= is_sub ? 1'b1 : ((i_MODE == MODE_ADC) ? i_CIN : 1'b0);
      cnt     <= '0;
      zacc_q  <= 1'b1;
    end else if (step) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sr_q    <= {cell_s, sr_q[WIDTH-1:1]};
      carry_q <= cell_cout;
      zacc_q  <= zacc_q & ~cell_s;
      cnt     <= cnt + CNT_W'(1);
      if (last_step) begin
        cout_q <= cell_cout;
        zero_q <= zacc_q & ~cell_s;
        if (mode_q != MODE_CMP) s_q <= {cell_s, sr_q[WIDTH-1:1]};
      end
    end
  end

  assign o_BUSY   = (state == RUN);
  assign o_SVALID = (state == RUN);
  assign o_DONE   = (state == DONE);
  assign o_SBIT   = cell_s;
  assign o_S      = s_q;
  assign o_COUT   = cout_q;
  assign o_ZERO   = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8 main instance, WIDTH=2 corner instance).
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          rst, cen, start, cin;
  logic [1:0]    mode;
  logic [W-1:0]  a, b;
  logic          busy, done, sbit, svalid, cout, zero;
  logic [W-1:0]  s;

  logic          start2, cin2;
  logic [1:0]    mode2;
  logic [1:0]    a2, b2;
  logic          busy2, done2, sbit2, svalid2, cout2, zero2;
  logic [1:0]    s2;

  int            total = 0;
  int            bad = 0;
  logic [W-1:0]  exp_s;

  serial_addsub #(.WIDTH(W)) dut (
    .i_CLK(clk), .i_RST(rst), .i_CEN(cen), .i_START(start), .i_MODE(mode),
    .i_CIN(cin), .i_A(a), .i_B(b), .o_BUSY(busy), .o_DONE(done),
    .o_SBIT(sbit), .o_SVALID(svalid), .o_S(s), .o_COUT(cout), .o_ZERO(zero)
  );

  serial_addsub #(.WIDTH(2)) dut2 (
    .i_CLK(clk), .i_RST(rst), .i_CEN(cen), .i_START(start2), .i_MODE(mode2),
    .i_CIN(cin2), .i_A(a2), .i_B(b2), .o_BUSY(busy2), .o_DONE(done2),
    .o_SBIT(sbit2), .o_SVALID(svalid2), .o_S(s2), .o_COUT(cout2), .o_ZERO(zero2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular arithmetic on the operands
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic [1:0] mm, input logic mc,
                                output logic [W-1:0] r, output logic co, output logic z);
    logic [W:0] full;
    full = '0;
    case (mm)
      MODE_SUB, MODE_CMP: begin
        r  = ma - mb;
        co = (ma >= mb);
      end
      MODE_ADC: begin
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        r = full[W-1:0];
        co = full[W];
      end
      default: begin
        full = {1'b0, ma} + {1'b0, mb};
        r = full[W-1:0];
        co = full[W];
      end
    endcase
    z = (r == '0);
  endfunction

  // Start an operation and wait for DONE; edges = enabled edges after start, -1 on timeout
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [1:0] tm,
                        input logic tc, input int div, output int edges, output logic [W-1:0] bits);
    int guard;
    int ph;
    a = ta; b = tb_; mode = tm; cin = tc; start = 1'b1; cen = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); mode = 2'($urandom); cin = 1'($urandom);
    edges = 0; guard = 0; ph = 0; bits = '0;
    while (!done && guard < 400) begin
      cen = ((ph % div) == 0);
      ph++;
      if (cen && svalid && edges < int'(W)) bits[edges] = sbit;
      tick();
      if (cen) edges++;
      guard++;
    end
    cen = 1'b1;
    if (!done) edges = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cen = 1'b0; start = 1'b0; mode = MODE_ADD; cin = 1'b0; a = '0; b = '0;
    start2 = 1'b0; mode2 = MODE_ADD; cin2 = 1'b0; a2 = '0; b2 = '0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (s !== '0) begin bad++; $display("FAIL reset_s: got %h want 00", s); end
    total++; if (cout !== 1'b0 || zero !== 1'b0) begin bad++; $display("FAIL reset_flags: got %b%b want 00", cout, zero); end
    total++; if (s2 !== 2'b00 || done2 !== 1'b0) begin bad++; $display("FAIL reset_w2: got s=%b done=%b want 00/0", s2, done2); end
    rst = 1'b0; cen = 1'b1;
    tick();
    exp_s = '0;
  endtask

  task automatic test_add;
    int e;
    logic [W-1:0] bits;
    run_op(8'h5A, 8'h33, MODE_ADD, 1'b0, 1, e, bits);
    total++; if (s !== 8'h8D) begin bad++; $display("FAIL add_s: got %h want 8d", s); end
    total++; if (cout !== 1'b0 || zero !== 1'b0) begin bad++; $display("FAIL add_flags: got c=%b z=%b want 0/0", cout, zero); end
    total++; if (e !== 8) begin bad++; $display("FAIL add_latency: got %0d want 8", e); end
    total++; if (bits !== 8'b1000_1101) begin bad++; $display("FAIL add_sbit: got %b want 10001101", bits); end
    exp_s = 8'h8D;
  endtask

  task automatic test_sub;
    int e;
    logic [W-1:0] bits;
    run_op(8'h10, 8'h20, MODE_SUB, 1'b0, 1, e, bits);
    total++; if (s !== 8'hF0 || cout !== 1'b0) begin bad++; $display("FAIL sub_borrow: got s=%h c=%b want f0/0", s, cout); end
    run_op(8'h20, 8'h20, MODE_SUB, 1'b1, 1, e, bits);
    total++; if (s !== 8'h00 || cout !== 1'b1 || zero !== 1'b1) begin bad++; $display("FAIL sub_equal: got s=%h c=%b z=%b want 00/1/1", s, cout, zero); end
    exp_s = 8'h00;
  endtask

  task automatic test_adc;
    int e;
    logic [W-1:0] bits;
    run_op(8'hFF, 8'h00, MODE_ADC, 1'b1, 1, e, bits);
    total++; if (s !== 8'h00 || cout !== 1'b1 || zero !== 1'b1) begin bad++; $display("FAIL adc_wrap: got s=%h c=%b z=%b want 00/1/1", s, cout, zero); end
    run_op(8'hFF, 8'h00, MODE_ADD, 1'b1, 1, e, bits);
    total++; if (s !== 8'hFF || cout !== 1'b0 || zero !== 1'b0) begin bad++; $display("FAIL add_nocin: got s=%h c=%b z=%b want ff/0/0", s, cout, zero); end
    exp_s = 8'hFF;
  endtask

  task automatic test_cmp;
    int e;
    logic [W-1:0] bits;
    run_op(8'h5A, 8'h33, MODE_ADD, 1'b0, 1, e, bits);
    run_op(8'h05, 8'h07, MODE_CMP, 1'b0, 1, e, bits);
    total++; if (s !== 8'h8D || cout !== 1'b0 || zero !== 1'b0) begin bad++; $display("FAIL cmp_lt: got s=%h c=%b z=%b want 8d/0/0", s, cout, zero); end
    run_op(8'h07, 8'h07, MODE_CMP, 1'b0, 1, e, bits);
    total++; if (s !== 8'h8D || cout !== 1'b1 || zero !== 1'b1) begin bad++; $display("FAIL cmp_eq: got s=%h c=%b z=%b want 8d/1/1", s, cout, zero); end
    exp_s = 8'h8D;
  endtask

  task automatic test_random;
    int e;
    logic [W-1:0] bits, ra, rb, r;
    logic [1:0] rm;
    logic rc, co, z;
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom); rb = W'($urandom); rm = 2'($urandom); rc = 1'($urandom);
      if (i == 0) begin ra = 8'hFF; rb = 8'h01; rm = MODE_ADD; end
      model(ra, rb, rm, rc, r, co, z);
      if (rm != MODE_CMP) exp_s = r;
      run_op(ra, rb, rm, rc, 1, e, bits);
      total++;
      if (s !== exp_s || cout !== co || zero !== z || e !== 8) begin
        bad++;
        $display("FAIL rand_%0d: a=%h b=%h m=%0d ci=%b got s=%h c=%b z=%b lat=%0d want s=%h c=%b z=%b lat=8",
                 i, ra, rb, rm, rc, s, cout, zero, e, exp_s, co, z);
      end
      if (rm != MODE_CMP) begin
        total++;
        if (bits !== r) begin bad++; $display("FAIL rand_sbit_%0d: got %h want %h", i, bits, r); end
      end
    end
  endtask

  task automatic test_cen;
    int e;
    logic [W-1:0] bits, r;
    logic co, z;
    model(8'hC3, 8'h7E, MODE_SUB, 1'b0, r, co, z);
    run_op(8'hC3, 8'h7E, MODE_SUB, 1'b0, 3, e, bits);
    exp_s = r;
    total++; if (s !== r || cout !== co || zero !== z) begin bad++; $display("FAIL cen_result: got s=%h c=%b z=%b want %h/%b/%b", s, cout, zero, r, co, z); end
    total++; if (e !== 8) begin bad++; $display("FAIL cen_latency: got %0d want 8", e); end
    cen = 1'b0;
    tick(); tick(); tick();
    total++; if (done !== 1'b1 || s !== r) begin bad++; $display("FAIL cen_freeze: got done=%b s=%h want 1/%h", done, s, r); end
    cen = 1'b1; start = 1'b0;
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_start_ignored;
    int e;
    int guard;
    a = 8'h5A; b = 8'h33; mode = MODE_ADD; cin = 1'b0; start = 1'b1; cen = 1'b1;
    tick();
    start = 1'b0; e = 0; guard = 0;
    while (!done && guard < 100) begin
      if (e == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; mode = MODE_ADC; cin = 1'b1; end
      tick();
      start = 1'b0;
      e++; guard++;
    end
    total++; if (s !== 8'h8D || e !== 8 || done !== 1'b1) begin bad++; $display("FAIL start_mid_run: got s=%h lat=%0d done=%b want 8d/8/1", s, e, done); end
    exp_s = 8'h8D;
  endtask

  task automatic test_back_to_back;
    int e;
    int guard;
    logic [W-1:0] bits;
    run_op(8'h11, 8'h22, MODE_ADD, 1'b0, 1, e, bits);
    a = 8'h40; b = 8'h41; mode = MODE_SUB; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_no_idle: got busy=%b done=%b want 1/0", busy, done); end
    total++; if (s !== 8'h33) begin bad++; $display("FAIL b2b_prev_s: got %h want 33", s); end
    e = 0; guard = 0;
    while (!done && guard < 100) begin tick(); e++; guard++; end
    total++; if (s !== 8'hFF || cout !== 1'b0 || e !== 8) begin bad++; $display("FAIL b2b_second: got s=%h c=%b lat=%0d want ff/0/8", s, cout, e); end
    exp_s = 8'hFF;
  endtask

  task automatic test_reset_mid;
    int e;
    logic [W-1:0] bits;
    a = 8'hAA; b = 8'h55; mode = MODE_ADD; cin = 1'b0; start = 1'b1; cen = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || svalid !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl: got busy=%b done=%b sv=%b want 0/0/0", busy, done, svalid); end
    total++; if (s !== '0 || cout !== 1'b0 || zero !== 1'b0) begin bad++; $display("FAIL rst_mid_out: got s=%h c=%b z=%b want 00/0/0", s, cout, zero); end
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || s !== '0) begin bad++; $display("FAIL rst_idle: got busy=%b s=%h want 0/00", busy, s); end
    run_op(8'h01, 8'h01, MODE_ADD, 1'b0, 1, e, bits);
    total++; if (s !== 8'h02 || cout !== 1'b0 || e !== 8) begin bad++; $display("FAIL rst_next: got s=%h c=%b lat=%0d want 02/0/8", s, cout, e); end
    exp_s = 8'h02;
  endtask

  task automatic test_w2;
    int e;
    int guard;
    a2 = 2'b11; b2 = 2'b01; mode2 = MODE_ADD; cin2 = 1'b0; start2 = 1'b1; cen = 1'b1;
    tick();
    start2 = 1'b0; e = 0; guard = 0;
    while (!done2 && guard < 50) begin tick(); e++; guard++; end
    total++; if (s2 !== 2'b00 || cout2 !== 1'b1 || zero2 !== 1'b1) begin bad++; $display("FAIL w2_add: got s=%b c=%b z=%b want 00/1/1", s2, cout2, zero2); end
    total++; if (e !== 2) begin bad++; $display("FAIL w2_latency: got %0d want 2", e); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_adc();
    test_cmp();
    test_random();
    test_cen();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_w2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
